// File: rtl/elevator_request_ctrl_if.sv
// Signal bundle between the button/sensor side and the elevator request front-end.
// The master drives the raw buttons, the floor sensors and the door flag; the slave returns the pending requests and the target.
interface elevator_request_ctrl_if;
    logic [2:0] BtnI;
    logic [2:0] BtnE;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       P;
    logic       I0;
    logic       I1;
    logic       I2;
    logic       E0;
    logic       E1;
    logic       E2;
    logic [1:0] Target;
    logic       Target_Valid;
    logic       Dir_Up;
    logic [1:0] Dbg_State;

    modport master (
        output BtnI, BtnE, S0, S1, S2, P,
        input  I0, I1, I2, E0, E1, E2, Target, Target_Valid, Dir_Up, Dbg_State
    );

    modport slave (
        input  BtnI, BtnE, S0, S1, S2, P,
        output I0, I1, I2, E0, E1, E2, Target, Target_Valid, Dir_Up, Dbg_State
    );
endinterface

// File: rtl/elevator_request_ctrl.sv
// Elevator request front-end: synchronises and debounces six buttons, latches pending requests,
// clears them on door-open service, and tracks a direction-aware next-target floor.
module elevator_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input logic                    Clk,
    input logic                    Reset,
    elevator_request_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] L_CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channels 0..2 are cabin buttons, 3..5 are hall buttons.
    logic [5:0]            w_raw;
    logic [5:0]            r_sync1;
    logic [5:0]            r_sync2;
    logic [5:0][CNT_W-1:0] r_cnt;
    logic [5:0]            r_armed;
    logic [5:0]            w_press;

    logic [2:0] r_req_i;
    logic [2:0] r_req_e;
    logic [2:0] w_req;
    logic [2:0] w_clr;
    logic [2:0] w_sensors;
    logic [1:0] r_floor;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_target;
    logic [1:0] w_target_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_dir_up;
    logic       w_dir_nxt;

    logic       w_ge_hit, w_gt_hit, w_le_hit, w_lt_hit;
    logic [1:0] w_ge_idx, w_gt_idx, w_le_idx, w_lt_idx;

    assign w_raw     = {bus.BtnE, bus.BtnI};
    assign w_sensors = {bus.S2, bus.S1, bus.S0};
    assign w_clr     = w_sensors & {3{bus.P}};
    assign w_req     = r_req_i | r_req_e;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_press = '0;
        for (int k = 0; k < 6; k++) begin
            w_press[k] = r_sync2[k] && (r_cnt[k] == L_CNT_FIRE) && r_armed[k];
        end
    end

    // A channel only re-arms after its synchronised input has been seen low.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_armed <= '0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (!r_sync2[k]) begin
                    r_cnt[k]   <= '0;
                    r_armed[k] <= 1'b1;
                end else begin
                    if (r_cnt[k] < L_CNT_MAX) r_cnt[k] <= r_cnt[k] + 1'b1;
                    if (w_press[k]) r_armed[k] <= 1'b0;
                end
            end
        end
    end

    // Service clear takes priority over a press arriving on the same edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_req_i <= '0;
            r_req_e <= '0;
        end else begin
            r_req_i <= (r_req_i | w_press[2:0]) & ~w_clr;
            r_req_e <= (r_req_e | w_press[5:3]) & ~w_clr;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_floor <= 2'd0;
        end else begin
            case (w_sensors)
                3'b001:  r_floor <= 2'd0;
                3'b010:  r_floor <= 2'd1;
                3'b100:  r_floor <= 2'd2;
                default: r_floor <= r_floor;
            endcase
        end
    end

    // Nearest pending floors relative to the current floor, in each direction.
    always_comb begin
        w_ge_hit = 1'b0;
        w_ge_idx = 2'd0;
        w_gt_hit = 1'b0;
        w_gt_idx = 2'd0;
        w_le_hit = 1'b0;
        w_le_idx = 2'd0;
        w_lt_hit = 1'b0;
        w_lt_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (w_req[k] && (k >= int'(r_floor))) begin
                w_ge_hit = 1'b1;
                w_ge_idx = 2'(k);
            end
            if (w_req[k] && (k > int'(r_floor))) begin
                w_gt_hit = 1'b1;
                w_gt_idx = 2'(k);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (w_req[k] && (k <= int'(r_floor))) begin
                w_le_hit = 1'b1;
                w_le_idx = 2'(k);
            end
            if (w_req[k] && (k < int'(r_floor))) begin
                w_lt_hit = 1'b1;
                w_lt_idx = 2'(k);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_target <= 2'd0;
            r_valid  <= 1'b0;
            r_dir_up <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_valid  <= w_valid_nxt;
            r_dir_up <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_valid_nxt  = r_valid;
        w_dir_nxt    = r_dir_up;
        if (w_req == 3'b000) begin
            w_state_nxt  = ST_IDLE;
            w_target_nxt = 2'd0;
            w_valid_nxt  = 1'b0;
        end else begin
            w_valid_nxt = 1'b1;
            case (r_state)
                ST_UP: begin
                    if (w_ge_hit) begin
                        w_state_nxt  = ST_UP;
                        w_target_nxt = w_ge_idx;
                        w_dir_nxt    = 1'b1;
                    end else begin
                        w_state_nxt  = ST_DOWN;
                        w_target_nxt = w_lt_idx;
                        w_dir_nxt    = 1'b0;
                    end
                end
                ST_DOWN: begin
                    if (w_le_hit) begin
                        w_state_nxt  = ST_DOWN;
                        w_target_nxt = w_le_idx;
                        w_dir_nxt    = 1'b0;
                    end else begin
                        w_state_nxt  = ST_UP;
                        w_target_nxt = w_gt_idx;
                        w_dir_nxt    = 1'b1;
                    end
                end
                default: begin
                    if (w_gt_hit) begin
                        w_state_nxt  = ST_UP;
                        w_target_nxt = w_ge_idx;
                        w_dir_nxt    = 1'b1;
                    end else if (w_lt_hit) begin
                        w_state_nxt  = ST_DOWN;
                        w_target_nxt = w_le_idx;
                        w_dir_nxt    = 1'b0;
                    end else begin
                        w_state_nxt  = r_dir_up ? ST_UP : ST_DOWN;
                        w_target_nxt = r_floor;
                    end
                end
            endcase
        end
    end

    assign bus.I0           = r_req_i[0];
    assign bus.I1           = r_req_i[1];
    assign bus.I2           = r_req_i[2];
    assign bus.E0           = r_req_e[0];
    assign bus.E1           = r_req_e[1];
    assign bus.E2           = r_req_e[2];
    assign bus.Target       = r_target;
    assign bus.Target_Valid = r_valid;
    assign bus.Dir_Up       = r_dir_up;
    assign bus.Dbg_State    = r_state;

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// Directed bench for elevator_request_ctrl: stimulus pushes {cycle, mask, value} expectations,
// a negedge monitor pops and compares them against the observed output vector.
module tb_elevator_request_ctrl;

    // Observed vector: {Target_Valid, Dir_Up, Target[1:0], I2, I1, I0, E2, E1, E0}
    localparam logic [9:0] M_I   = 10'b00_00_111_000;
    localparam logic [9:0] M_E   = 10'b00_00_000_111;
    localparam logic [9:0] M_T   = 10'b11_11_000_000;
    localparam logic [9:0] M_ALL = 10'b11_11_111_111;

    logic Clk;
    logic Reset;
    int   cyc;
    int   checks;
    int   errors;
    logic [35:0] exp_q[$];

    elevator_request_ctrl_if bus ();

    elevator_request_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [9:0] obs();
        return {bus.Target_Valid, bus.Dir_Up, bus.Target,
                bus.I2, bus.I1, bus.I0, bus.E2, bus.E1, bus.E0};
    endfunction

    function automatic logic [9:0] tv(input logic v, input logic d, input logic [1:0] t);
        return {v, d, t, 6'b0};
    endfunction

    task automatic compare(input string name, input logic [9:0] m, input logic [9:0] v);
        logic [9:0] got;
        got = obs();
        checks++;
        if ((got & m) !== (v & m)) begin
            errors++;
            $display("FAIL %s: got %b expected %b (mask %b)", name, got & m, v & m, m);
        end
    endtask

    task automatic push_exp(input int c, input logic [9:0] m, input logic [9:0] v);
        exp_q.push_back({c[15:0], m, v});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    always @(negedge Clk) begin
        logic [35:0] ent;
        while (exp_q.size() > 0 && exp_q[0][35:20] <= cyc[15:0]) begin
            ent = exp_q.pop_front();
            if (ent[35:20] != cyc[15:0]) begin
                checks++;
                errors++;
                $display("FAIL missed@cyc %0d: checked at cycle %0d", ent[35:20], cyc);
            end else begin
                compare($sformatf("chk@cyc %0d", cyc), ent[19:10], ent[9:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        checks    = 0;
        errors    = 0;
        Reset     = 1'b1;
        bus.BtnI  = 3'b111;
        bus.BtnE  = 3'b000;
        bus.S0    = 1'b0;
        bus.S1    = 1'b0;
        bus.S2    = 1'b0;
        bus.P     = 1'b0;

        // Buttons held through reset: requests appear only after the full latency.
        for (int k = 1; k <= 5; k++) push_exp(k, M_I, 10'b0);
        push_exp(6, M_I, 10'b00_00_111_000);
        #1 Reset = 1'b0;
        #2 compare("reset_state", M_ALL, tv(1'b0, 1'b1, 2'd0));
        #1 Reset = 1'b1;
        tick(7);
        bus.BtnI = 3'b000;
        Reset = 1'b0;
        #1 compare("async_reset_clears", M_ALL, tv(1'b0, 1'b1, 2'd0));
        #1 Reset = 1'b1;

        // Single held cabin press at floor 2 from floor 0, then served while still held.
        bus.S0 = 1'b1;
        tick(3);
        c = cyc;
        push_exp(c + 5, M_I, 10'b0);
        push_exp(c + 6, M_I, 10'b00_00_100_000);
        push_exp(c + 6, M_T, tv(1'b0, 1'b1, 2'd0));
        push_exp(c + 7, M_T, tv(1'b1, 1'b1, 2'd2));
        push_exp(c + 8, M_I, 10'b00_00_100_000);
        push_exp(c + 9, M_I, 10'b0);
        push_exp(c + 10, M_T, tv(1'b0, 1'b1, 2'd0));
        push_exp(c + 12, M_I, 10'b0);
        bus.BtnI = 3'b100;
        tick(8);
        bus.S0 = 1'b0;
        bus.S2 = 1'b1;
        bus.P  = 1'b1;
        tick(1);
        bus.P  = 1'b0;
        tick(1);
        bus.BtnI = 3'b000;
        tick(3);

        // Glitch of three synchronised cycles must never register.
        c = cyc;
        for (int k = 4; k <= 10; k++) push_exp(c + k, M_E, 10'b0);
        bus.BtnE = 3'b010;
        tick(3);
        bus.BtnE = 3'b000;
        tick(8);

        // Cabin and hall request at current floor 2, served by door-open.
        c = cyc;
        push_exp(c + 5, M_I | M_E, 10'b0);
        push_exp(c + 6, M_I | M_E, 10'b00_00_100_100);
        push_exp(c + 7, M_T, tv(1'b1, 1'b1, 2'd2));
        push_exp(c + 9, M_I | M_E | M_T, tv(1'b1, 1'b1, 2'd2));
        push_exp(c + 10, M_T, tv(1'b0, 1'b1, 2'd0));
        bus.BtnI = 3'b100;
        bus.BtnE = 3'b100;
        tick(7);
        bus.BtnI = 3'b000;
        bus.BtnE = 3'b000;
        tick(1);
        bus.P = 1'b1;
        tick(1);
        bus.P = 1'b0;
        tick(2);

        // From floor 1 going up: E2 served first, then reverse down to I0.
        bus.S2 = 1'b0;
        bus.S1 = 1'b1;
        tick(2);
        c = cyc;
        push_exp(c + 7, M_T, tv(1'b1, 1'b1, 2'd2));
        push_exp(c + 13, M_I, 10'b00_00_001_000);
        push_exp(c + 14, M_T, tv(1'b1, 1'b1, 2'd2));
        push_exp(c + 15, M_E, 10'b00_00_000_100);
        push_exp(c + 16, M_E, 10'b0);
        push_exp(c + 17, M_T, tv(1'b1, 1'b0, 2'd0));
        push_exp(c + 19, M_I, 10'b0);
        push_exp(c + 20, M_T, tv(1'b0, 1'b0, 2'd0));
        bus.BtnE = 3'b100;
        tick(7);
        bus.BtnE = 3'b000;
        bus.BtnI = 3'b001;
        tick(8);
        bus.S1 = 1'b0;
        bus.S2 = 1'b1;
        bus.P  = 1'b1;
        tick(1);
        bus.P    = 1'b0;
        bus.BtnI = 3'b000;
        tick(2);
        bus.S2 = 1'b0;
        bus.S0 = 1'b1;
        bus.P  = 1'b1;
        tick(1);
        bus.P = 1'b0;
        tick(2);

        // Press pulse for E1 lands on the same edge as the floor-1 service clear.
        bus.S0 = 1'b0;
        bus.S1 = 1'b1;
        tick(2);
        c = cyc;
        push_exp(c + 6, M_E, 10'b0);
        push_exp(c + 7, M_E | M_T, tv(1'b0, 1'b0, 2'd0));
        push_exp(c + 9, M_E, 10'b0);
        bus.BtnE = 3'b010;
        tick(5);
        bus.P = 1'b1;
        tick(1);
        bus.P = 1'b0;
        tick(4);
        bus.BtnE = 3'b000;
        tick(3);

        // Reset while the I1 counter sits at 2: the full latency restarts.
        c = cyc;
        for (int k = 6; k <= 9; k++) push_exp(c + k, M_I, 10'b0);
        push_exp(c + 10, M_I, 10'b00_00_010_000);
        push_exp(c + 11, M_T, tv(1'b1, 1'b1, 2'd1));
        bus.BtnI = 3'b010;
        tick(4);
        Reset = 1'b0;
        #1 compare("mid_debounce_reset", M_ALL, tv(1'b0, 1'b1, 2'd0));
        #1 Reset = 1'b1;
        tick(8);
        bus.BtnI = 3'b000;

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick(1);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
